if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the instruction memory. Owns the program counter and drives the PC to the combinational instruction memory. Captures the returned word into the IF/ID pipeline register. Handles stall, branch/jump redirect with flush, and misaligned-target trapping for the RV32I core.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_WIDTH, 32, program counter width
INST_WIDTH, 32, instruction width
NOP_INST, 32'h0000_0013, bubble encoding (ADDI x0,x0,0) loaded into IF/ID on flush or reset

Ports:
clk  in  1  core clock, rising edge
rst  in  1  reset, asynchronous, active-high
PC  out  PC_WIDTH  fetch address to instruction memory
inst  in  INST_WIDTH  instruction word returned combinationally for PC
stall_i  in  1  hold fetch and IF/ID contents
redirect_i  in  1  branch/jump taken; load redirect_pc_i and flush IF/ID
redirect_pc_i  in  PC_WIDTH  redirect target
ifid_valid_o  out  1  IF/ID holds a real instruction
ifid_pc_o  out  PC_WIDTH  PC of the IF/ID instruction
ifid_pc4_o  out  PC_WIDTH  ifid_pc_o + 4, for JAL/JALR link
ifid_inst_o  out  INST_WIDTH  captured instruction
misalign_o  out  1  fetch halted on misaligned redirect target
trap_pc_o  out  PC_WIDTH  offending target address
fetch_cnt_o  out  32  performance counter; see Optional Feature
stall_cnt_o  out  32  performance counter; see Optional Feature

Behaviour:
- Reset (asynchronous, immediate) sets:
  - PC=RESET_PC, state=BOOT
  - ifid_valid_o=0, ifid_pc_o=0, ifid_pc4_o=0, ifid_inst_o=NOP_INST
  - misalign_o=0, trap_pc_o=0, both counters 0
- FSM states: BOOT, RUN, TRAP.
- BOOT:
  - Lasts exactly one cycle after reset deasserts; PC is driven but nothing is captured.
  - Next state is RUN unconditionally, even if stall_i is high.
  - redirect_i in BOOT is honoured as in RUN.
- RUN, per rising edge, priority redirect > stall > advance:
  - redirect_i=1:
    - PC<=redirect_pc_i; ifid_valid_o<=0; ifid_inst_o<=NOP_INST.
    - If redirect_pc_i[1:0]!=0: PC is still loaded, misalign_o<=1, trap_pc_o<=redirect_pc_i, next state TRAP.
  - stall_i=1, no redirect: PC and all IF/ID outputs hold.
  - Otherwise (advance):
    - ifid_pc_o<=PC; ifid_pc4_o<=PC+4; ifid_inst_o<=inst; ifid_valid_o<=1.
    - PC<=PC+4.
- TRAP:
  - ifid_valid_o=0 and PC holds; stall_i is ignored.
  - An aligned redirect clears misalign_o, loads PC, and returns to RUN. The first capture happens on the following edge.
  - A misaligned redirect stays in TRAP and updates trap_pc_o.
- Arithmetic: PC+4 is modulo 2^PC_WIDTH; 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- Alignment: PC[1:0] is always 00 in RUN, so the memory never returns high-Z to this stage.
- Latency: an instruction at PC appears on ifid_*_o one edge after PC is presented. Redirect-to-first-valid latency is 2 edges (1 flush bubble).
- Simultaneous redirect_i and stall_i: redirect wins and the flush still occurs.
- Reset asserted mid-operation returns all state to reset values asynchronously; a BOOT cycle follows deassertion.

Optional Feature:
FETCH_PERF_CNT_EN.
- Defined:
  - fetch_cnt_o increments on every advance edge (valid capture).
  - stall_cnt_o increments on every RUN edge with stall_i=1 and redirect_i=0.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are synthesised; ports remain present.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INST constant and default RESET_PC
  - Width constants (XLEN=32, INST_WIDTH=32)
  - FSM state encoding: BOOT=2'd0, RUN=2'd1, TRAP=2'd2
- One natural sub-module: if_id_reg. Holds valid/pc/pc4/inst with load, hold and flush controls, and is reused by later pipeline registers.
- PC, FSM and counters live in the top.

Test Plan:
- Reset with RESET_PC=0, memory word0=32'h00500093, word1=32'h00A00113; release reset.
  - Expect BOOT for 1 cycle.
  - Then ifid_inst_o=32'h00500093 with ifid_pc_o=0, ifid_pc4_o=4, valid=1.
  - Next edge ifid_inst_o=32'h00A00113 with ifid_pc_o=4.
- stall_i high for 3 cycles at PC=8:
  - PC stays 8 and IF/ID holds the PC=4 entry.
  - After release, the PC=8 instruction is captured.
  - With FETCH_PERF_CNT_EN, stall_cnt_o=3.
- redirect_i with redirect_pc_i=32'h40 while stall_i=1:
  - Next edge ifid_valid_o=0, ifid_inst_o=32'h13, PC=32'h40.
  - Following edge ifid_pc_o=32'h40, valid=1.
- redirect_pc_i=32'h42:
  - misalign_o=1, trap_pc_o=32'h42, valid stays 0 across stall toggling.
  - A further redirect to 32'h80 clears misalign_o and resumes fetch at 32'h80.
- Force PC to 32'hFFFF_FFFC via redirect, then advance:
  - ifid_pc_o=32'hFFFF_FFFC, ifid_pc4_o=0, next PC=0.
- Assert rst asynchronously mid-RUN (between edges):
  - Outputs return to reset values immediately with ifid_inst_o=NOP_INST.
  - Counters read 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I core definitions used by the fetch stage and later pipeline
// registers: datapath widths, bubble encoding, default reset PC and the fetch
// FSM state type.
// No ports.
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    // ADDI x0,x0,0: canonical bubble loaded into pipeline registers on flush.
    localparam logic [ILEN-1:0] RV_NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] RV_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StTrap = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_if
// Bundles the fetch stage signals: instruction-memory address/data, pipeline
// control from later stages, IF/ID register outputs, trap status and the
// performance counters.
// Modports:
//   master : the fetch unit (drives PC, IF/ID, trap and counter outputs)
//   slave  : memory / downstream pipeline / control (drives inst, stall,
//            redirect)
// ----------------------------------------------------------------------------
interface if_fetch_unit_if #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INST_WIDTH = 32
);
    logic [PC_WIDTH-1:0]   PC;
    logic [INST_WIDTH-1:0] inst;
    logic                  stall_i;
    logic                  redirect_i;
    logic [PC_WIDTH-1:0]   redirect_pc_i;
    logic                  ifid_valid_o;
    logic [PC_WIDTH-1:0]   ifid_pc_o;
    logic [PC_WIDTH-1:0]   ifid_pc4_o;
    logic [INST_WIDTH-1:0] ifid_inst_o;
    logic                  misalign_o;
    logic [PC_WIDTH-1:0]   trap_pc_o;
    logic [31:0]           fetch_cnt_o;
    logic [31:0]           stall_cnt_o;

    modport master (
        output PC,
        input  inst,
        input  stall_i,
        input  redirect_i,
        input  redirect_pc_i,
        output ifid_valid_o,
        output ifid_pc_o,
        output ifid_pc4_o,
        output ifid_inst_o,
        output misalign_o,
        output trap_pc_o,
        output fetch_cnt_o,
        output stall_cnt_o
    );

    modport slave (
        input  PC,
        output inst,
        output stall_i,
        output redirect_i,
        output redirect_pc_i,
        input  ifid_valid_o,
        input  ifid_pc_o,
        input  ifid_pc4_o,
        input  ifid_inst_o,
        input  misalign_o,
        input  trap_pc_o,
        input  fetch_cnt_o,
        input  stall_cnt_o
    );

endinterface

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// Pipeline register holding valid / pc / pc+4 / instruction. Flush has
// priority over load; with neither asserted the contents hold.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_load       : capture i_pc / i_inst, mark valid
//   i_flush      : insert bubble (valid=0, inst=NOP_INST), pc fields hold
//   i_pc, i_inst : incoming PC and instruction
//   o_valid, o_pc, o_pc4, o_inst : registered contents
// ----------------------------------------------------------------------------
module if_id_reg #(
    parameter int unsigned             PC_WIDTH   = 32,
    parameter int unsigned             INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0]   NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_flush,
    input  logic [PC_WIDTH-1:0]   i_pc,
    input  logic [INST_WIDTH-1:0] i_inst,
    output logic                  o_valid,
    output logic [PC_WIDTH-1:0]   o_pc,
    output logic [PC_WIDTH-1:0]   o_pc4,
    output logic [INST_WIDTH-1:0] o_inst
);

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    logic                  r_valid;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_pc4;
    logic [INST_WIDTH-1:0] r_inst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_inst  <= NOP_INST;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_pc4   <= i_pc + PC_STEP;
            r_inst  <= i_inst;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_inst  = r_inst;

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// RV32I instruction-fetch stage. Owns the PC, presents it to a combinational
// instruction memory and captures the returned word into the IF/ID register.
// Per edge the priority is redirect > stall > advance. A redirect to a
// non-word-aligned target parks the unit in a trap state until an aligned
// redirect arrives.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : if_fetch_unit_if.master (PC/inst, stall/redirect, IF/ID
//              outputs, misalign/trap_pc, performance counters)
// Build option:
//   FETCH_PERF_CNT_EN - when defined, fetch_cnt_o / stall_cnt_o count advance
//   edges and stalled RUN edges; otherwise both are tied to zero.
// ----------------------------------------------------------------------------
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned           PC_WIDTH   = XLEN,
    parameter int unsigned           INST_WIDTH = ILEN,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = RV_RESET_PC,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = RV_NOP_INST
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_unit_if.master  bus
);

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    fetch_state_e          r_state;
    fetch_state_e          w_state_next;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   w_pc_next;
    logic                  r_misalign;
    logic                  w_misalign_next;
    logic [PC_WIDTH-1:0]   r_trap_pc;
    logic [PC_WIDTH-1:0]   w_trap_pc_next;
    logic                  w_advance;
    logic                  w_flush;
    logic                  w_target_misaligned;

    logic                  w_ifid_valid;
    logic [PC_WIDTH-1:0]   w_ifid_pc;
    logic [PC_WIDTH-1:0]   w_ifid_pc4;
    logic [INST_WIDTH-1:0] w_ifid_inst;

    assign w_target_misaligned = |bus.redirect_pc_i[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StBoot;
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
            r_trap_pc  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_misalign <= w_misalign_next;
            r_trap_pc  <= w_trap_pc_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_misalign_next = r_misalign;
        w_trap_pc_next  = r_trap_pc;
        w_advance       = 1'b0;
        w_flush         = 1'b0;

        unique case (r_state)
            StBoot, StRun: begin
                if (bus.redirect_i) begin
                    // The target is loaded even when misaligned so the
                    // offending address is visible on PC as well.
                    w_pc_next = bus.redirect_pc_i;
                    w_flush   = 1'b1;
                    if (w_target_misaligned) begin
                        w_misalign_next = 1'b1;
                        w_trap_pc_next  = bus.redirect_pc_i;
                        w_state_next    = StTrap;
                    end else begin
                        w_state_next    = StRun;
                    end
                end else if (r_state == StBoot) begin
                    // Boot edge: PC is presented but nothing is captured.
                    w_state_next = StRun;
                end else if (!bus.stall_i) begin
                    w_advance = 1'b1;
                    w_pc_next = r_pc + PC_STEP;
                end
            end
            StTrap: begin
                if (bus.redirect_i) begin
                    w_flush = 1'b1;
                    if (w_target_misaligned) begin
                        w_trap_pc_next = bus.redirect_pc_i;
                    end else begin
                        w_misalign_next = 1'b0;
                        w_pc_next       = bus.redirect_pc_i;
                        w_state_next    = StRun;
                    end
                end
            end
            default: begin
                w_state_next = StBoot;
            end
        endcase
    end

    if_id_reg #(
        .PC_WIDTH   (PC_WIDTH),
        .INST_WIDTH (INST_WIDTH),
        .NOP_INST   (NOP_INST)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_advance),
        .i_flush (w_flush),
        .i_pc    (r_pc),
        .i_inst  (bus.inst),
        .o_valid (w_ifid_valid),
        .o_pc    (w_ifid_pc),
        .o_pc4   (w_ifid_pc4),
        .o_inst  (w_ifid_inst)
    );

    assign bus.PC           = r_pc;
    assign bus.ifid_valid_o = w_ifid_valid;
    assign bus.ifid_pc_o    = w_ifid_pc;
    assign bus.ifid_pc4_o   = w_ifid_pc4;
    assign bus.ifid_inst_o  = w_ifid_inst;
    assign bus.misalign_o   = r_misalign;
    assign bus.trap_pc_o    = r_trap_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_stall_run;

    assign w_stall_run = (r_state == StRun) && bus.stall_i && !bus.redirect_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_advance) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_stall_run) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign bus.fetch_cnt_o = r_fetch_cnt;
    assign bus.stall_cnt_o = r_stall_cnt;
`else
    assign bus.fetch_cnt_o = '0;
    assign bus.stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized
// run compared against a behavioural model of the fetch rules.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] WORD0 = 32'h0050_0093;
    localparam logic [31:0] WORD1 = 32'h00A0_0113;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    if_fetch_unit_if bus ();

    if_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return WORD0;
        if (a == 32'h4) return WORD1;
        return a ^ 32'h5A5A_0003;
    endfunction

    assign bus.inst = mem_word(bus.PC);

    // Reference model: mode 0 = boot, 1 = run, 2 = trap.
    int          m_mode;
    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_inst, m_trap;
    bit          m_valid, m_mis;
    int unsigned m_fetch, m_stall;

    task automatic model_reset();
        m_mode = 0; m_pc = 32'h0; m_ifpc = 0; m_ifpc4 = 0; m_inst = NOP;
        m_trap = 0; m_valid = 0; m_mis = 0; m_fetch = 0; m_stall = 0;
    endtask

    function automatic logic [31:0] exp_fetch();
`ifdef FETCH_PERF_CNT_EN
        return m_fetch;
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [31:0] exp_stall();
`ifdef FETCH_PERF_CNT_EN
        return m_stall;
`else
        return 32'h0;
`endif
    endfunction

    // Drive inputs, advance the model by one edge, sample 1 time unit after it.
    task automatic cycle(input bit s, input bit r, input logic [31:0] rp);
        bus.stall_i       = s;
        bus.redirect_i    = r;
        bus.redirect_pc_i = rp;
        if (m_mode != 2) begin
            if (r) begin
                m_pc = rp; m_valid = 0; m_inst = NOP;
                if (rp % 4 != 0) begin
                    m_mis = 1; m_trap = rp; m_mode = 2;
                end else begin
                    m_mode = 1;
                end
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (s) begin
                m_stall++;
            end else begin
                m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4; m_inst = mem_word(m_pc);
                m_valid = 1; m_pc = m_pc + 32'd4; m_fetch++;
            end
        end else if (r) begin
            m_valid = 0; m_inst = NOP;
            if (rp % 4 != 0) begin
                m_trap = rp;
            end else begin
                m_mis = 0; m_pc = rp; m_mode = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.stall_i = 0; bus.redirect_i = 0; bus.redirect_pc_i = 0;
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.PC !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", bus.PC, 32'h0); end
        total++; if (bus.ifid_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.ifid_valid_o); end
        total++; if (bus.ifid_inst_o !== NOP) begin bad++; $display("FAIL reset_inst got=%h exp=%h", bus.ifid_inst_o, NOP); end
        total++; if ({bus.ifid_pc_o, bus.ifid_pc4_o, bus.trap_pc_o} !== 96'h0) begin bad++; $display("FAIL reset_pcs got=%h/%h/%h exp=0", bus.ifid_pc_o, bus.ifid_pc4_o, bus.trap_pc_o); end
        total++; if (bus.misalign_o !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=0", bus.misalign_o); end
        total++; if ({bus.fetch_cnt_o, bus.stall_cnt_o} !== 64'h0) begin bad++; $display("FAIL reset_cnt got=%h/%h exp=0", bus.fetch_cnt_o, bus.stall_cnt_o); end
        rst = 0;
    endtask

    task automatic test_boot_fetch();
        cycle(1, 0, 0);  // stall is ignored in BOOT
        total++; if (bus.ifid_valid_o !== 1'b0 || bus.PC !== 32'h0) begin bad++; $display("FAIL boot_edge got valid=%b pc=%h exp valid=0 pc=0", bus.ifid_valid_o, bus.PC); end
        cycle(0, 0, 0);
        total++; if (bus.ifid_inst_o !== WORD0 || bus.ifid_pc_o !== 32'h0 || bus.ifid_pc4_o !== 32'h4 || bus.ifid_valid_o !== 1'b1) begin
            bad++; $display("FAIL first_fetch got inst=%h pc=%h pc4=%h v=%b exp inst=%h pc=0 pc4=4 v=1", bus.ifid_inst_o, bus.ifid_pc_o, bus.ifid_pc4_o, bus.ifid_valid_o, WORD0); end
        cycle(0, 0, 0);
        total++; if (bus.ifid_inst_o !== WORD1 || bus.ifid_pc_o !== 32'h4 || bus.PC !== 32'h8) begin
            bad++; $display("FAIL second_fetch got inst=%h pc=%h PC=%h exp inst=%h pc=4 PC=8", bus.ifid_inst_o, bus.ifid_pc_o, bus.PC, WORD1); end
    endtask

    task automatic test_stall();
        logic [31:0] st0;
        st0 = bus.stall_cnt_o;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0);
            total++; if (bus.PC !== 32'h8 || bus.ifid_pc_o !== 32'h4 || bus.ifid_inst_o !== WORD1) begin
                bad++; $display("FAIL stall_hold[%0d] got PC=%h ifpc=%h inst=%h exp PC=8 ifpc=4 inst=%h", i, bus.PC, bus.ifid_pc_o, bus.ifid_inst_o, WORD1); end
        end
        total++;
`ifdef FETCH_PERF_CNT_EN
        if (bus.stall_cnt_o - st0 !== 32'd3) begin bad++; $display("FAIL stall_cnt got=%0d exp=3", bus.stall_cnt_o - st0); end
`else
        if (bus.stall_cnt_o !== 32'h0) begin bad++; $display("FAIL stall_cnt got=%0d exp=0 (st0=%0d)", bus.stall_cnt_o, st0); end
`endif
        cycle(0, 0, 0);
        total++; if (bus.ifid_pc_o !== 32'h8 || bus.ifid_inst_o !== mem_word(32'h8) || bus.ifid_valid_o !== 1'b1) begin
            bad++; $display("FAIL stall_release got pc=%h inst=%h v=%b exp pc=8 inst=%h v=1", bus.ifid_pc_o, bus.ifid_inst_o, bus.ifid_valid_o, mem_word(32'h8)); end
    endtask

    task automatic test_redirect_stall();
        cycle(1, 1, 32'h40);
        total++; if (bus.ifid_valid_o !== 1'b0 || bus.ifid_inst_o !== NOP || bus.PC !== 32'h40) begin
            bad++; $display("FAIL redirect_flush got v=%b inst=%h PC=%h exp v=0 inst=%h PC=40", bus.ifid_valid_o, bus.ifid_inst_o, bus.PC, NOP); end
        cycle(0, 0, 0);
        total++; if (bus.ifid_pc_o !== 32'h40 || bus.ifid_valid_o !== 1'b1) begin
            bad++; $display("FAIL redirect_first got pc=%h v=%b exp pc=40 v=1", bus.ifid_pc_o, bus.ifid_valid_o); end
    endtask

    task automatic test_misalign();
        cycle(0, 1, 32'h42);
        total++; if (bus.misalign_o !== 1'b1 || bus.trap_pc_o !== 32'h42 || bus.ifid_valid_o !== 1'b0) begin
            bad++; $display("FAIL misalign_enter got mis=%b trap=%h v=%b exp mis=1 trap=42 v=0", bus.misalign_o, bus.trap_pc_o, bus.ifid_valid_o); end
        for (int i = 0; i < 4; i++) begin
            cycle(i[0], 0, 0);
            total++; if (bus.ifid_valid_o !== 1'b0 || bus.misalign_o !== 1'b1 || bus.PC !== 32'h42) begin
                bad++; $display("FAIL trap_hold[%0d] got v=%b mis=%b PC=%h exp v=0 mis=1 PC=42", i, bus.ifid_valid_o, bus.misalign_o, bus.PC); end
        end
        cycle(0, 1, 32'h80);
        total++; if (bus.misalign_o !== 1'b0 || bus.PC !== 32'h80 || bus.ifid_valid_o !== 1'b0) begin
            bad++; $display("FAIL trap_exit got mis=%b PC=%h v=%b exp mis=0 PC=80 v=0", bus.misalign_o, bus.PC, bus.ifid_valid_o); end
        cycle(0, 0, 0);
        total++; if (bus.ifid_pc_o !== 32'h80 || bus.ifid_valid_o !== 1'b1 || bus.ifid_inst_o !== mem_word(32'h80)) begin
            bad++; $display("FAIL trap_resume got pc=%h v=%b inst=%h exp pc=80 v=1", bus.ifid_pc_o, bus.ifid_valid_o, bus.ifid_inst_o); end
    endtask

    task automatic test_wrap();
        cycle(0, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 0);
        total++; if (bus.ifid_pc_o !== 32'hFFFF_FFFC || bus.ifid_pc4_o !== 32'h0 || bus.PC !== 32'h0) begin
            bad++; $display("FAIL pc_wrap got ifpc=%h pc4=%h PC=%h exp ifpc=fffffffc pc4=0 PC=0", bus.ifid_pc_o, bus.ifid_pc4_o, bus.PC); end
    endtask

    task automatic test_random();
        bit s, r;
        logic [31:0] rp;
        for (int i = 0; i < 400; i++) begin
            s  = ($urandom_range(0, 99) < 30);
            r  = ($urandom_range(0, 99) < 12);
            rp = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
            if ($urandom_range(0, 19) == 0) rp = 32'hFFFF_FFF8;
            cycle(s, r, rp);
            total++; if (bus.PC !== m_pc) begin bad++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, bus.PC, m_pc); end
            total++; if (bus.ifid_valid_o !== m_valid || bus.ifid_inst_o !== m_inst) begin
                bad++; $display("FAIL rnd_ifid[%0d] got v=%b inst=%h exp v=%b inst=%h", i, bus.ifid_valid_o, bus.ifid_inst_o, m_valid, m_inst); end
            total++; if (bus.ifid_pc_o !== m_ifpc || bus.ifid_pc4_o !== m_ifpc4) begin
                bad++; $display("FAIL rnd_ifpc[%0d] got %h/%h exp %h/%h", i, bus.ifid_pc_o, bus.ifid_pc4_o, m_ifpc, m_ifpc4); end
            total++; if (bus.misalign_o !== m_mis || bus.trap_pc_o !== m_trap) begin
                bad++; $display("FAIL rnd_trap[%0d] got mis=%b trap=%h exp mis=%b trap=%h", i, bus.misalign_o, bus.trap_pc_o, m_mis, m_trap); end
            total++; if (bus.fetch_cnt_o !== exp_fetch() || bus.stall_cnt_o !== exp_stall()) begin
                bad++; $display("FAIL rnd_cnt[%0d] got %0d/%0d exp %0d/%0d", i, bus.fetch_cnt_o, bus.stall_cnt_o, exp_fetch(), exp_stall()); end
        end
    endtask

    task automatic test_async_reset();
        cycle(0, 1, 32'h100);
        repeat (3) cycle(0, 0, 0);
        #2;
        rst = 1;
        #1;
        model_reset();
        total++; if (bus.PC !== 32'h0 || bus.ifid_valid_o !== 1'b0 || bus.ifid_inst_o !== NOP || bus.ifid_pc_o !== 32'h0) begin
            bad++; $display("FAIL async_reset got PC=%h v=%b inst=%h ifpc=%h exp PC=0 v=0 inst=%h ifpc=0", bus.PC, bus.ifid_valid_o, bus.ifid_inst_o, bus.ifid_pc_o, NOP); end
        total++; if (bus.fetch_cnt_o !== 32'h0 || bus.stall_cnt_o !== 32'h0) begin
            bad++; $display("FAIL async_reset_cnt got %0d/%0d exp 0/0", bus.fetch_cnt_o, bus.stall_cnt_o); end
        @(negedge clk);
        rst = 0;
        cycle(0, 0, 0);
        total++; if (bus.ifid_valid_o !== 1'b0 || bus.PC !== 32'h0) begin
            bad++; $display("FAIL reboot_edge got v=%b PC=%h exp v=0 PC=0", bus.ifid_valid_o, bus.PC); end
        cycle(0, 0, 0);
        total++; if (bus.ifid_valid_o !== 1'b1 || bus.ifid_inst_o !== WORD0 || bus.PC !== 32'h4) begin
            bad++; $display("FAIL reboot_fetch got v=%b inst=%h PC=%h exp v=1 inst=%h PC=4", bus.ifid_valid_o, bus.ifid_inst_o, bus.PC, WORD0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_boot_fetch();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_wrap();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
